// File: rtl/status_stack_reg_pkg.sv
// Shared constants and types for the status register with hardware shadow stack.
// Field layout of the 6-bit status word: [5] mode, [4] imask, [3:0] ALU flags.
package status_stack_reg_pkg;

  localparam int STATUS_WIDTH = 6;
  localparam int ALU_LSB      = 0;
  localparam int ALU_W        = 4;
  localparam int IMASK_BIT    = 4;
  localparam int MODE_LSB     = 5;

  // Trap entry forces supervisor mode (mode=0) with interrupts masked (imask=1)
  localparam logic [STATUS_WIDTH-1:0] STATUS_ENTRY_MASK =
    STATUS_WIDTH'((1 << MODE_LSB) | (1 << IMASK_BIT));
  localparam logic [STATUS_WIDTH-1:0] STATUS_ENTRY_VAL =
    STATUS_WIDTH'(1 << IMASK_BIT);

  typedef struct packed {
    logic             mode;
    logic             imask;
    logic [ALU_W-1:0] alu;
  } status_t;

  typedef enum logic [2:0] {
    OP_SWAP_LOAD,
    OP_PUSH,
    OP_PUSH_FULL,
    OP_POP,
    OP_POP_EMPTY,
    OP_LOAD
  } stack_op_e;

endpackage

// File: rtl/status_stack_reg_if.sv
// Control/status bundle between the control unit (master) and the status stack (slave).
interface status_stack_reg_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             oe_a;
  logic             oe_b;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] ld_mask;
  logic             push;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] value;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output oe_a, oe_b, in, ld_mask, push, pop, clr_err,
    input  value, count, full, empty, overflow, underflow
  );

  modport slave (
    input  oe_a, oe_b, in, ld_mask, push, pop, clr_err,
    output value, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/status_stack_reg_lifo_mem.sv
// DEPTH x WIDTH register array backing the shadow stack; cleared on reset.
module lifo_mem #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/status_stack_reg.sv
// Status word with per-bit load, dual tri-state read ports and a hardware shadow
// stack used to save/restore the word across trap entry and return.
module status_stack_reg
  import status_stack_reg_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] INITIAL_VAL = '0,
  parameter logic [WIDTH-1:0] ENTRY_MASK  = WIDTH'(STATUS_ENTRY_MASK),
  parameter logic [WIDTH-1:0] ENTRY_VAL   = WIDTH'(STATUS_ENTRY_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  status_stack_reg_if.slave bus,
  output tri   [WIDTH-1:0] a,
  output tri   [WIDTH-1:0] b
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] value_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] entry_word;
  logic [WIDTH-1:0] load_word;
  stack_op_e        op;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign entry_word = (value_q & ~ENTRY_MASK) | (ENTRY_VAL & ENTRY_MASK);
  assign load_word  = (value_q & ~bus.ld_mask) | (bus.in & bus.ld_mask);

  // Simultaneous push and pop cancel out on the stack and fall back to a plain load
  always_comb begin
    op = OP_LOAD;
    if (bus.push && bus.pop) op = OP_SWAP_LOAD;
    else if (bus.push)       op = full  ? OP_PUSH_FULL : OP_PUSH;
    else if (bus.pop)        op = empty ? OP_POP_EMPTY : OP_POP;
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (op == OP_PUSH),
    .wr_ptr  (PW'(count_q)),
    .wr_data (value_q),
    .rd_ptr  (PW'(count_q - 1'b1)),
    .rd_data (rd_data)
  );

  // Error flags are cleared first so that a same-cycle error set takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q     <= INITIAL_VAL;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      case (op)
        OP_SWAP_LOAD: value_q <= load_word;
        OP_PUSH: begin
          value_q <= entry_word;
          count_q <= count_q + 1'b1;
        end
        OP_PUSH_FULL: begin
          value_q    <= entry_word;
          overflow_q <= 1'b1;
        end
        OP_POP: begin
          value_q <= rd_data;
          count_q <= count_q - 1'b1;
        end
        OP_POP_EMPTY: underflow_q <= 1'b1;
        default:      value_q <= load_word;
      endcase
    end
  end

  assign a = bus.oe_a ? value_q : 'z;
  assign b = bus.oe_b ? value_q : 'z;

  assign bus.value     = value_q;
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_status_stack_reg.sv
// Directed-vector bench: the driver queues hand-computed expectations and a
// negedge monitor pops and compares them against the DUT.
module tb_status_stack_reg;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  wire  [5:0] a_bus;
  wire  [5:0] b_bus;

  status_stack_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  status_stack_reg #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .INITIAL_VAL (6'h00),
    .ENTRY_MASK  (6'b110000),
    .ENTRY_VAL   (6'b010000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .a   (a_bus),
    .b   (b_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] value;
    logic [2:0] count;
    logic       ovf;
    logic       unf;
    bit         bus_chk;
    logic       oe_a;
    logic       oe_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkReleased(input string name, input logic [5:0] act, input logic [5:0] driven);
    checks++;
    if (act === driven) begin
      errors++;
      $display("[TB] FAIL %s: bus still shows %h while disabled", name, act);
    end
  endtask

  // Monitor: one expectation per clock, compared on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput({mon_e.name, ".value"}, {2'b00, bus.value}, {2'b00, mon_e.value});
      checkOutput({mon_e.name, ".count"}, {5'd0, bus.count}, {5'd0, mon_e.count});
      checkOutput({mon_e.name, ".full"}, {7'd0, bus.full}, {7'd0, mon_e.count == 3'd4});
      checkOutput({mon_e.name, ".empty"}, {7'd0, bus.empty}, {7'd0, mon_e.count == 3'd0});
      checkOutput({mon_e.name, ".overflow"}, {7'd0, bus.overflow}, {7'd0, mon_e.ovf});
      checkOutput({mon_e.name, ".underflow"}, {7'd0, bus.underflow}, {7'd0, mon_e.unf});
      if (mon_e.bus_chk) begin
        if (mon_e.oe_a) checkOutput({mon_e.name, ".a"}, {2'b00, a_bus}, {2'b00, mon_e.value});
        else            checkReleased({mon_e.name, ".a_off"}, a_bus, mon_e.value);
        if (mon_e.oe_b) checkOutput({mon_e.name, ".b"}, {2'b00, b_bus}, {2'b00, mon_e.value});
        else            checkReleased({mon_e.name, ".b_off"}, b_bus, mon_e.value);
      end
    end
  end

  task automatic pushExp(input string name, input logic [5:0] value, input logic [2:0] count,
                         input logic ovf, input logic unf, input bit bus_chk);
    exp_t e;
    e.name    = name;
    e.value   = value;
    e.count   = count;
    e.ovf     = ovf;
    e.unf     = unf;
    e.bus_chk = bus_chk;
    e.oe_a    = bus.oe_a;
    e.oe_b    = bus.oe_b;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input string name, input logic [5:0] in_v, input logic [5:0] ld,
                               input logic push, input logic pop, input logic clr,
                               input logic oe_a, input logic oe_b,
                               input logic [5:0] exp_value, input logic [2:0] exp_count,
                               input logic exp_ovf, input logic exp_unf, input bit bus_chk);
    @(negedge clk);
    #1;
    bus.in      = in_v;
    bus.ld_mask = ld;
    bus.push    = push;
    bus.pop     = pop;
    bus.clr_err = clr;
    bus.oe_a    = oe_a;
    bus.oe_b    = oe_b;
    @(posedge clk);
    #1;
    pushExp(name, exp_value, exp_count, exp_ovf, exp_unf, bus_chk);
  endtask

  // Reset raised just after a rising edge must take effect before the next one
  task automatic resetMidCycle(input string name);
    @(negedge clk);
    #1;
    bus.ld_mask = '0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    bus.oe_a    = 1'b0;
    bus.oe_b    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    pushExp(name, 6'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.in      = '0;
    bus.ld_mask = '0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    bus.oe_a    = 1'b0;
    bus.oe_b    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("reset_state", 6'h00, 6'h00, 0, 0, 0, 0, 0, 6'h00, 3'd0, 0, 0, 0);
    applyStimulus("load_2a",     6'h2A, 6'h3F, 0, 0, 0, 0, 0, 6'h2A, 3'd0, 0, 0, 0);
    applyStimulus("push_2a",     6'h00, 6'h00, 1, 0, 0, 0, 0, 6'h1A, 3'd1, 0, 0, 0);
    resetMidCycle("mid_reset");
    applyStimulus("pop_after_rst", 6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h00, 3'd0, 0, 1, 0);
    applyStimulus("clr_unf0",    6'h00, 6'h00, 0, 0, 1, 0, 0, 6'h00, 3'd0, 0, 0, 0);

    applyStimulus("mask_load",   6'h3F, 6'h03, 0, 0, 0, 0, 0, 6'h03, 3'd0, 0, 0, 0);
    applyStimulus("bus_both",    6'h00, 6'h00, 0, 0, 0, 1, 1, 6'h03, 3'd0, 0, 0, 1);
    applyStimulus("bus_a_only",  6'h00, 6'h00, 0, 0, 0, 1, 0, 6'h03, 3'd0, 0, 0, 1);
    applyStimulus("bus_off",     6'h00, 6'h00, 0, 0, 0, 0, 0, 6'h03, 3'd0, 0, 0, 1);

    applyStimulus("load_05",     6'h05, 6'h3F, 0, 0, 0, 0, 0, 6'h05, 3'd0, 0, 0, 0);
    applyStimulus("push_05",     6'h2A, 6'h3F, 1, 0, 0, 0, 0, 6'h15, 3'd1, 0, 0, 0);
    applyStimulus("pop_05",      6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h05, 3'd0, 0, 0, 0);

    for (int v = 1; v <= 4; v++) begin
      applyStimulus($sformatf("fill_load%0d", v), 6'(v), 6'h3F, 0, 0, 0, 0, 0,
                    6'(v), 3'(v - 1), 0, 0, 0);
      applyStimulus($sformatf("fill_push%0d", v), 6'h00, 6'h00, 1, 0, 0, 0, 0,
                    6'h10 | 6'(v), 3'(v), 0, 0, 0);
    end
    applyStimulus("fill_load5",  6'h05, 6'h3F, 0, 0, 0, 0, 0, 6'h05, 3'd4, 0, 0, 0);
    applyStimulus("push_full",   6'h00, 6'h00, 1, 0, 0, 0, 0, 6'h15, 3'd4, 1, 0, 0);
    applyStimulus("push_full_clr", 6'h00, 6'h00, 1, 0, 1, 0, 0, 6'h15, 3'd4, 1, 0, 0);
    applyStimulus("drain_pop4",  6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h04, 3'd3, 1, 0, 0);
    applyStimulus("drain_pop3",  6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h03, 3'd2, 1, 0, 0);
    applyStimulus("drain_pop2",  6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h02, 3'd1, 1, 0, 0);
    applyStimulus("drain_pop1",  6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h01, 3'd0, 1, 0, 0);
    applyStimulus("clr_ovf",     6'h00, 6'h00, 0, 0, 1, 0, 0, 6'h01, 3'd0, 0, 0, 0);

    applyStimulus("pop_empty",   6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h01, 3'd0, 0, 1, 0);
    applyStimulus("pop_empty_clr", 6'h00, 6'h00, 0, 1, 1, 0, 0, 6'h01, 3'd0, 0, 1, 0);
    applyStimulus("clr_unf",     6'h00, 6'h00, 0, 0, 1, 0, 0, 6'h01, 3'd0, 0, 0, 0);

    applyStimulus("push_01",     6'h00, 6'h00, 1, 0, 0, 0, 0, 6'h11, 3'd1, 0, 0, 0);
    applyStimulus("push_and_pop", 6'h3C, 6'h3F, 1, 1, 0, 0, 0, 6'h3C, 3'd1, 0, 0, 0);
    applyStimulus("pop_after_pp", 6'h00, 6'h00, 0, 1, 0, 0, 0, 6'h01, 3'd0, 0, 0, 0);

    @(negedge clk);
    #1;
    bus.pop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_stack_reg.md
Name: status_stack_reg

Overview:
- Parametrised successor to the CPU status register: a WIDTH-bit status word with per-bit load, dual tri-state bus read ports, and a DEPTH-entry hardware shadow stack.
- On interrupt/trap entry the control unit pushes the live status. A fixed entry pattern (e.g. imask set, supervisor mode) is applied in the same cycle.
- On return, pop restores the saved word.
- Sits beside the register file; drives buses a/b. Its value output feeds the ALU, interrupt controller and mode logic.

Parameters:
- WIDTH, 6, status word width.
- DEPTH, 4, shadow stack entries (>=1).
- INITIAL_VAL, 0, value after reset.
- ENTRY_MASK, 6'b110000, bits forced on push.
- ENTRY_VAL, 6'b010000, values of those forced bits on push.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a  out tri  WIDTH  bus A; driven with value when oe_a, else high-Z
- b  out tri  WIDTH  bus B; driven with value when oe_b, else high-Z
- oe_a  in  1  output enable, bus A
- oe_b  in  1  output enable, bus B
- in  in  WIDTH  load data
- ld_mask  in  WIDTH  per-bit load enable; all-ones = full load
- push  in  1  save value, apply entry pattern
- pop  in  1  restore top of stack
- clr_err  in  1  clear sticky error flags
- value  out  WIDTH  current status word
- count  out  $clog2(DEPTH+1)  occupied entries
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, immediate):
  - value=INITIAL_VAL, count=0, overflow=0, underflow=0.
  - All stack entries=0.
  - a/b remain purely combinational on oe.
- a/b: combinational, zero latency from value/oe; both ports may be enabled at once.
- Per rising edge, exactly one case applies, in this priority order:
  1. push & pop together: stack and count unchanged. value loads per ld_mask: bit i <= in[i] where ld_mask[i]. Flags unchanged.
  2. push, not full:
     - stack[count] <= value (pre-edge value).
     - count+1.
     - value <= (value & ~ENTRY_MASK) | (ENTRY_VAL & ENTRY_MASK).
     - ld_mask ignored.
  3. push, full:
     - Stack and count unchanged; overflow <= 1.
     - value still gets the entry pattern, so the handler runs masked.
     - ld_mask ignored.
  4. pop, not empty: value <= stack[count-1]; count-1; ld_mask ignored.
  5. pop, empty: value unchanged; underflow <= 1; ld_mask ignored.
  6. Otherwise: bitwise masked load from in.
- Saved value is visible on value one cycle after pop. Push then pop in consecutive cycles restores the original word exactly.
- clr_err clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- full/empty are combinational from count. count never exceeds DEPTH and never wraps below 0.
- Reset asserted mid-sequence discards all stacked entries.

Decomposition:
- reg_pkg gains:
  - status field index constants (ALU_LSB, ALU_W, IMASK_BIT, MODE_LSB);
  - STATUS_ENTRY_MASK/VAL defaults;
  - an optional status_t for WIDTH=6.
- One sub-module, lifo_mem (DEPTH x WIDTH register array with write/read pointer port, reset-to-zero), keeps the stack storage separable from the control and priority logic.

Test Plan:
- Reset with value=6'h2A, then rst pulse mid-cycle -> value=INITIAL_VAL immediately, count=0, a/b high-Z with oe low.
- ld_mask=6'b000011, in=6'h3F, value=0 -> value=6'h03. Then oe_a=oe_b=1 -> a=b=6'h03.
- value=6'h05, push -> next cycle value=6'h15, count=1. Then pop -> value=6'h05, count=0, empty=1.
- Push 5 times with DEPTH=4, values 1..5 -> count=4, full=1, overflow=1 after 5th push. Then pops return 4,3,2,1 in order.
- Pop with count=0 -> value unchanged, underflow=1. clr_err and pop together -> underflow stays 1. clr_err alone -> 0.
- push&pop together with ld_mask=6'h3F, in=6'h3C -> count unchanged, value=6'h3C.
